// File: rtl/interrupt_pkg.sv
// Shared constants for the interrupt controller: state encoding and field widths.
package interrupt_pkg;

  localparam int unsigned NUM_IRQ_DEFAULT = 4;
  localparam int unsigned ID_W            = 2;
  localparam int unsigned STATE_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_SERV_MI  = 2'd1,
    ST_SERV_NMI = 2'd2
  } state_t;

endpackage

// File: rtl/irq_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge pulse for one request line.
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [2:0] warm;

  // warm marks when prev holds a real sample, so a line held high through reset is not seen as an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      warm  <= 3'b000;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
      warm  <= {warm[1:0], 1'b1};
    end
  end

  assign rise_c = warm[2] & sync2 & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt controller: pending/mask registers, lowest-index
// priority, NMI path and a three-state service FSM.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               savePC,
  input  logic               INA,
  input  logic               eoi,
  output logic               interrupt,
  output logic               nmint,
  output logic               busy,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [STATE_W-1:0] state
);

  state_t             st;
  state_t             st_nxt;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pending_nxt;
  logic               nmi_rise;
  logic               nmi_pend;
  logic               nmi_pend_nxt;
  logic               any_active;
  logic [ID_W-1:0]    enc;
  logic [ID_W-1:0]    id_lat;
  logic [ID_W-1:0]    id_lat_nxt;
  logic               take_mi;
  logic               take_nmi;
  logic               interrupt_nxt;
  logic               nmint_nxt;

  for (genvar i = 0; i < int'(NUM_IRQ); i++) begin : g_sync
    irq_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (irq[i]),
      .rise_c(rise[i])
    );
  end

  irq_edge_sync u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nmi_in),
    .rise_c(nmi_rise)
  );

  // Lowest enabled pending index wins
  always_comb begin
    active     = pending & mask;
    any_active = |active;
    enc        = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active[i]) enc = ID_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= ST_IDLE;
    else       st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    take_mi  = 1'b0;
    take_nmi = 1'b0;
    case (st)
      ST_IDLE: begin
        if (savePC) begin
          if (INA) begin
            st_nxt  = ST_SERV_MI;
            take_mi = 1'b1;
          end else begin
            st_nxt   = ST_SERV_NMI;
            take_nmi = 1'b1;
          end
        end
      end
      ST_SERV_MI, ST_SERV_NMI: begin
        if (eoi) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  // A new edge overrides a same-cycle clear; a spurious ack clears nothing
  always_comb begin
    clr           = take_mi ? (active & (~active + NUM_IRQ'(1))) : '0;
    pending_nxt   = (pending & ~clr) | rise;
    nmi_pend_nxt  = (nmi_pend & ~take_nmi) | nmi_rise;
    id_lat_nxt    = (take_mi | take_nmi) ? enc : id_lat;
    interrupt_nxt = any_active & (st == ST_IDLE);
    nmint_nxt     = nmi_pend & (st == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      nmi_pend  <= 1'b0;
      mask      <= '0;
      id_lat    <= '0;
      interrupt <= 1'b0;
      nmint     <= 1'b0;
    end else begin
      pending   <= pending_nxt;
      nmi_pend  <= nmi_pend_nxt;
      id_lat    <= id_lat_nxt;
      interrupt <= interrupt_nxt;
      nmint     <= nmint_nxt;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign busy   = (st != ST_IDLE);
  assign irq_id = (st == ST_IDLE) ? enc : id_lat;
  assign state  = st;

endmodule
